// File: rtl/fp_mul_scheduler.sv
// fp_mul_scheduler
//   Shares one external IEEE 754 single-precision multiplier among NUM_REQ
//   requesters. A round-robin arbiter grants one request at a time. The
//   granted operands are registered onto mul_a/mul_b and held for
//   MUL_LATENCY cycles. The product is then registered and offered on a
//   single tagged response channel.
//
// Parameters:
//   NUM_REQ      number of requesters (2..8)
//   MUL_LATENCY  cycles from stable mul_a/mul_b to a valid mul_result (1..8)
//
// Ports:
//   clk, rst         rising-edge clock; asynchronous active-high reset
//   req_valid/ready  per-requester handshake; req_ready is one-hot
//   req_a, req_b     packed operands, requester i at [32*i+31:32*i]
//   mul_a, mul_b     operands to the shared multiplier (registered)
//   mul_result       product returned by the shared multiplier
//   resp_valid/ready response handshake
//   resp_data        registered product
//   resp_id          index of the requester that owns resp_data
//   busy             high in any state except IDLE
//
// Optional feature (macro FP_MUL_SPECIAL_EN):
//   The operands are classified at grant time. Zero, Inf and NaN cases force
//   a fixed result. EXEC still runs for MUL_LATENCY cycles, so the latency
//   does not change.
module fp_mul_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  output logic [31:0]            mul_a,
  output logic [31:0]            mul_b,
  input  logic [31:0]            mul_result,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_data,
  output logic [ID_W-1:0]        resp_id,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_next;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] scan_idx;
  logic            grant_found;
  logic [3:0]      cnt;
  logic [31:0]     sel_a, sel_b;

  // Round-robin search. Start one past last_grant and wrap at NUM_REQ,
  // so the most recently served requester is considered last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (scan_idx == ID_W'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Operand mux for the winning requester
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

`ifdef FP_MUL_SPECIAL_EN
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, spec_sign;
  logic        spec_hit, spec_hit_q;
  logic [31:0] spec_val, spec_val_q;

  // Exponent 0 is treated as zero, so denormals flush to zero.
  // Exponent 255 is Inf when the mantissa is zero and NaN otherwise.
  assign a_zero    = (sel_a[30:23] == 8'h00);
  assign b_zero    = (sel_b[30:23] == 8'h00);
  assign a_inf     = (sel_a[30:23] == 8'hFF) && (sel_a[22:0] == 23'h0);
  assign b_inf     = (sel_b[30:23] == 8'hFF) && (sel_b[22:0] == 23'h0);
  assign a_nan     = (sel_a[30:23] == 8'hFF) && (sel_a[22:0] != 23'h0);
  assign b_nan     = (sel_b[30:23] == 8'hFF) && (sel_b[22:0] != 23'h0);
  assign spec_sign = sel_a[31] ^ sel_b[31];

  always_comb begin
    spec_hit = 1'b0;
    spec_val = '0;
    if (a_nan || b_nan || (a_zero && b_inf) || (b_zero && a_inf)) begin
      spec_hit = 1'b1;
      spec_val = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      spec_hit = 1'b1;
      spec_val = {spec_sign, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      spec_hit = 1'b1;
      spec_val = {spec_sign, 31'h0};
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_found)  state_next = EXEC;
      EXEC:    if (cnt == 4'd1)  state_next = RESP;
      RESP:    if (resp_ready)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rst also gates req_ready, so no grant shows while reset is asserted
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found && !rst) req_ready[grant_idx] = 1'b1;
    resp_valid = (state == RESP);
    busy       = (state != IDLE);
  end

  // Datapath registers. The operands stay on mul_a/mul_b for all of EXEC.
  // The result is captured on the last EXEC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a      <= '0;
      mul_b      <= '0;
      resp_data  <= '0;
      resp_id    <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      cnt        <= '0;
`ifdef FP_MUL_SPECIAL_EN
      spec_hit_q <= 1'b0;
      spec_val_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            mul_a      <= sel_a;
            mul_b      <= sel_b;
            resp_id    <= grant_idx;
            last_grant <= grant_idx;
            cnt        <= 4'(MUL_LATENCY);
`ifdef FP_MUL_SPECIAL_EN
            spec_hit_q <= spec_hit;
            spec_val_q <= spec_val;
`endif
          end
        end
        EXEC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
`ifdef FP_MUL_SPECIAL_EN
            resp_data <= spec_hit_q ? spec_val_q : mul_result;
`else
            resp_data <= mul_result;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// tb_fp_mul_scheduler
//   Bench for fp_mul_scheduler. u_dut uses MUL_LATENCY=1 and is driven by a
//   combinational stand-in multiplier. A transaction-level reference model
//   checks it cycle by cycle. u_dut4 uses MUL_LATENCY=4 and is driven by a
//   pipelined stand-in multiplier. It covers the long-latency timing and
//   the reset that aborts an operation.
//   The stand-in multiplier always assumes an implicit leading one and
//   truncates the result. It only needs to be deterministic, because the
//   block passes the product through unchanged.
module tb_fp_mul_scheduler;

  localparam int NUM_REQ = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, resp_valid, resp_ready, busy;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic [31:0]  mul_a, mul_b, mul_result, resp_data;
  logic [1:0]   resp_id;

  logic         rst_4, resp_valid_4, resp_ready_4, busy_4;
  logic [3:0]   req_valid_4, req_ready_4;
  logic [127:0] req_a_4, req_b_4;
  logic [31:0]  mul_a_4, mul_b_4, mul_result_4, resp_data_4;
  logic [1:0]   resp_id_4;

  logic [31:0]  op_a [NUM_REQ];
  logic [31:0]  op_b [NUM_REQ];
  logic [31:0]  pipe_a [3];
  logic [31:0]  pipe_b [3];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state, kept as transactions
  int          m_last;
  bit          m_busy, m_resp;
  int          m_due, m_id, m_grant;
  logic [31:0] m_data, m_a, m_b;
  int          grants[$];

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e = {2'b0, x[30:23]} + {2'b0, y[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {x[31] ^ y[31], e[7:0], m};
  endfunction

  function automatic logic [31:0] expect_result(input logic [31:0] x, input logic [31:0] y);
`ifdef FP_MUL_SPECIAL_EN
    bit xz, yz, xi, yi, xn, yn;
    logic s;
    xz = (x[30:23] == 8'h00);
    yz = (y[30:23] == 8'h00);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
    s  = x[31] ^ y[31];
    if (xn || yn || (xz && yi) || (yz && xi)) return 32'h7FC0_0000;
    if (xi || yi) return {s, 8'hFF, 23'h0};
    if (xz || yz) return {s, 31'h0};
`endif
    return fmul(x, y);
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[30:23] = 8'h00;
      1: r[30:23] = 8'hFF;
      2: begin r[30:23] = 8'hFF; r[22:0] = 23'h0; end
      default: ;
    endcase
    return r;
  endfunction

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32] = op_a[i];
      req_b[32*i +: 32] = op_b[i];
    end
  end

  assign mul_result = fmul(mul_a, mul_b);

  always @(posedge clk) begin
    pipe_a[0] <= mul_a_4;
    pipe_a[1] <= pipe_a[0];
    pipe_a[2] <= pipe_a[1];
    pipe_b[0] <= mul_b_4;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mul_result_4 = fmul(pipe_a[2], pipe_b[2]);

  fp_mul_scheduler #(.NUM_REQ(4), .MUL_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
  );

  fp_mul_scheduler #(.NUM_REQ(4), .MUL_LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst_4), .req_valid(req_valid_4), .req_ready(req_ready_4),
    .req_a(req_a_4), .req_b(req_b_4), .mul_a(mul_a_4), .mul_b(mul_b_4),
    .mul_result(mul_result_4), .resp_valid(resp_valid_4), .resp_ready(resp_ready_4),
    .resp_data(resp_data_4), .resp_id(resp_id_4), .busy(busy_4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int predict_grant(input logic [3:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (m_last + k) % NUM_REQ;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last  = NUM_REQ - 1;
    m_busy  = 1'b0;
    m_resp  = 1'b0;
    m_due   = 0;
    m_grant = -1;
  endtask

  // Compare u_dut with the model for the current cycle, then advance the
  // model across the coming clock edge.
  task automatic check_output();
    logic [3:0] exp_ready;
    int g;
    exp_ready = '0;
    g = -1;
    if (!m_busy) begin
      g = predict_grant(req_valid);
      if (g >= 0) exp_ready = 4'(1 << g);
    end
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("resp_valid", 32'(resp_valid), 32'(m_resp));
    if (m_busy) begin
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
    end
    if (m_resp) begin
      chk("resp_data", resp_data, m_data);
      chk("resp_id", 32'(resp_id), 32'(m_id));
    end
    m_grant = -1;
    if (!m_busy) begin
      if (g >= 0) begin
        m_busy  = 1'b1;
        m_due   = 1;
        m_a     = op_a[g];
        m_b     = op_b[g];
        m_data  = expect_result(op_a[g], op_b[g]);
        m_id    = g;
        m_last  = g;
        m_grant = g;
        grants.push_back(g);
      end
    end else if (!m_resp) begin
      m_due--;
      if (m_due == 0) m_resp = 1'b1;
    end else if (resp_ready) begin
      m_resp = 1'b0;
      m_busy = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] v, input logic rr);
    @(posedge clk);
    #1;
    req_valid  = v;
    resp_ready = rr;
    @(negedge clk);
    check_output();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("pulse_busy", 32'(busy), 32'h0);
    chk("pulse_mul_a", mul_a, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int exp_order[5];
    logic [3:0] pend;
    logic rr;

    rst = 1'b1; rst_4 = 1'b1;
    req_valid = 4'b1111; resp_ready = 1'b0;
    req_valid_4 = '0; resp_ready_4 = 1'b0; req_a_4 = '0; req_b_4 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_mul_a", mul_a, 32'h0);
    chk("rst_mul_b", mul_b, 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_id", 32'(resp_id), 32'h0);
    chk("rst4_busy", 32'(busy_4), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; rst_4 = 1'b0; req_valid = '0;

    // 2.0 x 3.0 from requester 0
    op_a[0] = 32'h4000_0000; op_b[0] = 32'h4040_0000;
    apply_stimulus(4'b0001, 1'b1);
    chk("tp1_ready", 32'(req_ready), 32'h1);
    apply_stimulus(4'b0000, 1'b1);
    chk("tp1_early_valid", 32'(resp_valid), 32'h0);
    apply_stimulus(4'b0000, 1'b1);
    chk("tp1_valid", 32'(resp_valid), 32'h1);
    chk("tp1_data", resp_data, 32'h40C0_0000);
    chk("tp1_id", 32'(resp_id), 32'h0);

    // -1.5 x 2.0 from requester 2
    op_a[2] = 32'hBFC0_0000; op_b[2] = 32'h4000_0000;
    apply_stimulus(4'b0100, 1'b1);
    apply_stimulus(4'b0000, 1'b1);
    apply_stimulus(4'b0000, 1'b1);
    chk("tp2_data", resp_data, 32'hC040_0000);
    chk("tp2_id", 32'(resp_id), 32'h2);

    // Round robin with every requester asserted, starting from reset
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = rand_operand();
      op_b[i] = rand_operand();
    end
    grants.delete();
    repeat (15) apply_stimulus(4'b1111, 1'b1);
    exp_order = '{0, 1, 2, 3, 0};
    chk("rr_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("rr_order", (i < grants.size()) ? 32'(grants[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));

    // Backpressure while the other requesters wait
    apply_stimulus(4'b0010, 1'b0);
    apply_stimulus(4'b1101, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(4'b1101, 1'b0);
      chk("bp_ready_low", 32'(req_ready), 32'h0);
      chk("bp_valid_held", 32'(resp_valid), 32'h1);
    end
    apply_stimulus(4'b1101, 1'b1);
    apply_stimulus(4'b1101, 1'b1);
    chk("bp_next_grant", 32'(req_ready), 32'h4);
    apply_stimulus(4'b0000, 1'b1);
    apply_stimulus(4'b0000, 1'b1);

    // Special operands
    op_a[3] = 32'h0000_0000; op_b[3] = 32'h4040_0000;
    apply_stimulus(4'b1000, 1'b1);
    apply_stimulus(4'b0000, 1'b1);
    apply_stimulus(4'b0000, 1'b1);
`ifdef FP_MUL_SPECIAL_EN
    chk("sp_zero", resp_data, 32'h0000_0000);
`else
    chk("sp_zero", resp_data, 32'h00C0_0000);
`endif
    op_a[0] = 32'h7F80_0000; op_b[0] = 32'h0000_0000;
    apply_stimulus(4'b0001, 1'b1);
    apply_stimulus(4'b0000, 1'b1);
    apply_stimulus(4'b0000, 1'b1);
`ifdef FP_MUL_SPECIAL_EN
    chk("sp_inf_zero", resp_data, 32'h7FC0_0000);
`else
    chk("sp_inf_zero", resp_data, 32'h4000_0000);
`endif

    // Random traffic. A pending request is held until it is granted, and
    // it may be withdrawn only in cycles when no grant can happen.
    pend = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == m_grant) continue;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          op_a[i] = rand_operand();
          op_b[i] = rand_operand();
        end else if (pend[i] && m_busy && $urandom_range(0, 9) == 0) begin
          pend[i] = 1'b0;
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      apply_stimulus(pend, rr);
      if (m_grant >= 0) pend[m_grant[1:0]] = 1'b0;
    end

    // MUL_LATENCY=4: 1.0 x 5.0, grant at T, response at T+5
    req_a_4 = {96'd0, 32'h3F80_0000};
    req_b_4 = {96'd0, 32'h40A0_0000};
    resp_ready_4 = 1'b1;
    @(posedge clk); #1; req_valid_4 = 4'b0001;
    @(negedge clk);
    chk("l4_ready", 32'(req_ready_4), 32'h1);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1; req_valid_4 = '0;
      @(negedge clk);
      chk("l4_wait_valid", 32'(resp_valid_4), 32'h0);
      chk("l4_busy", 32'(busy_4), 32'h1);
      chk("l4_mul_a", mul_a_4, 32'h3F80_0000);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("l4_valid", 32'(resp_valid_4), 32'h1);
    chk("l4_data", resp_data_4, 32'h40A0_0000);
    chk("l4_id", 32'(resp_id_4), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l4_idle", 32'(busy_4), 32'h0);

    // Reset in EXEC aborts the operation of requester 2
    req_a_4[95:64] = 32'h4000_0000;
    req_b_4[95:64] = 32'h4040_0000;
    @(posedge clk); #1; req_valid_4 = 4'b0100;
    @(negedge clk);
    chk("ab_ready", 32'(req_ready_4), 32'h4);
    @(posedge clk); #1; req_valid_4 = '0;
    #2; rst_4 = 1'b1;
    #1;
    chk("ab_busy", 32'(busy_4), 32'h0);
    chk("ab_mul_a", mul_a_4, 32'h0);
    chk("ab_resp_valid", 32'(resp_valid_4), 32'h0);
    @(posedge clk); #1; rst_4 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("ab_no_resp", 32'(resp_valid_4), 32'h0);
      @(posedge clk); #1;
    end
    req_valid_4 = 4'b1111;
    @(negedge clk);
    chk("ab_prio0", 32'(req_ready_4), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_mul_scheduler.md
Name: fp_mul_scheduler

Overview:
- Shares one IEEE 754 single-precision multiplier among NUM_REQ requesters, e.g. DSP MAC lanes or the FPU issue port.
- Round-robin arbitration, valid/ready request handshake, operand/result registering, and a single tagged response channel.
- The multiplier sits outside this block, on the mul_a/mul_b/mul_result ports; its latency is set by MUL_LATENCY, so a pipelined multiplier can replace the combinational one later.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID_W = clog2(NUM_REQ), derived locally.
- MUL_LATENCY, 1, cycles from operands stable on mul_a/mul_b to mul_result valid (1..8).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  one-hot grant/accept; handshake = req_valid[i] & req_ready[i]
- req_a  input  NUM_REQ*32  packed operand A; requester i at [32*i+31:32*i]
- req_b  input  NUM_REQ*32  packed operand B, same packing
- mul_a  output  32  operand A to shared multiplier
- mul_b  output  32  operand B to shared multiplier
- mul_result  input  32  product from shared multiplier
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_data  output  32  product
- resp_id  output  ID_W  index of the requester that owns resp_data
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset:
  - State goes to IDLE; all outputs are 0.
  - mul_a, mul_b, resp_data and resp_id registers clear to 0.
  - last_grant is set to NUM_REQ-1, so requester 0 has highest priority first.
- States are IDLE, EXEC and RESP.
- IDLE:
  - If any req_valid is high, grant the first set bit searching upward from last_grant+1, with modulo NUM_REQ wrap.
  - req_ready[g] is high in the same cycle, combinationally from state and req_valid. All other req_ready bits are 0. req_ready is 0 in every other state.
  - On that edge: latch req_a[g] into mul_a and req_b[g] into mul_b, set resp_id to g, set last_grant to g, load cnt with MUL_LATENCY, and go to EXEC.
  - No valid requests: stay in IDLE with no change.
- EXEC:
  - mul_a and mul_b are held stable. cnt decrements every cycle.
  - In the cycle where cnt==1, capture mul_result into resp_data and go to RESP.
- RESP:
  - resp_valid is 1. resp_data and resp_id are held stable while resp_ready is 0, with no limit.
  - On resp_valid & resp_ready: go to IDLE and clear resp_valid on that edge.
- Latency: if the grant is at cycle T, resp_valid rises at T+MUL_LATENCY+1. Minimum issue interval is MUL_LATENCY+2 cycles.
- A requester may drop req_valid before it is granted. Nothing is latched for it and it is not counted as a grant.
- Dropping req_valid in the same cycle as the grant is invalid stimulus. The bench must not generate it.
- A requester granted in the last round has lowest priority next round, including when it is the only one requesting.
- Asynchronous rst in EXEC or RESP aborts the operation: no response is emitted, and the state and registers return to their reset values immediately.
- resp_ready high outside RESP is ignored.
- The block performs no arithmetic except the optional special-case logic below. The sign, exponent and mantissa come from mul_result unchanged.

Optional Feature:
- Macro: FP_MUL_SPECIAL_EN.
- Defined: at grant time the operands are classified. Exp field 0 counts as zero (denormals flush to zero); exp field 255 counts as Inf/NaN. The cases below set a bypass flag and a forced result. EXEC is still taken for the full MUL_LATENCY, so latency stays fixed, but resp_data loads the forced value instead of mul_result. sign = a[31]^b[31].
  - Either operand NaN, or zero×Inf: 32'h7FC00000.
  - Otherwise, either operand Inf: {sign, 8'hFF, 23'h0}.
  - Otherwise, either operand zero: {sign, 31'h0}.
- Undefined: no classification logic; resp_data always takes mul_result.

Test Plan:
- Single op, MUL_LATENCY=1: req_valid=4'b0001, A=40000000, B=40400000 (2.0×3.0) at cycle T -> req_ready=0001 at T, resp_valid at T+2, resp_data=40C00000, resp_id=0.
- Sign handling: requester 2 sends BFC00000×40000000 (-1.5×2.0) -> resp_data=C0400000, resp_id=2.
- Round-robin: all four req_valid held high continuously, resp_ready=1 -> grant order 0,1,2,3,0. No grant overlaps an active EXEC or RESP.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_data and resp_id held constant, req_ready=0000. Release -> IDLE next cycle, then the next grant.
- Reset mid-EXEC with MUL_LATENCY=4: assert rst during EXEC -> resp_valid never rises, busy=0 and mul_a=0 immediately. After release, requester 0 gets priority.
- Special case, 00000000×40400000 -> resp_data=00000000 with FP_MUL_SPECIAL_EN defined, 00C00000 without it. Also 7F800000×00000000 -> 7FC00000 with the macro defined.
